// File: rtl/pll_ps_pkg.sv
// Shared types and constants for the PLL dynamic phase-shift stepper.
package pll_ps_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_GAP,
        ST_RST,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic OP_STEP = 1'b0;
    localparam logic OP_HOME = 1'b1;

    localparam int POS_W = 6;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_ps_timer.sv
// Loadable down-counter that parks at zero; one instance times PULSE, GAP, RST and WAIT.
module pll_ps_timer #(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pll_phase_stepper.sv
// Sequences PLL dynamic phase-shift pulses and HOME resets from MCU commands,
// tracking the phase position of every PLL output.
module pll_phase_stepper
    import pll_ps_pkg::*;
#(
    parameter int NUM_OUT         = 2,
    parameter int STEPS_PER_CYCLE = 40,
    parameter int PULSE_CYC       = 2,
    parameter int GAP_CYC         = 8,
    parameter int RST_CYC         = 16,
    parameter int LOCK_WAIT       = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_op,
    input  logic [2:0]               cmd_sel,
    input  logic                     cmd_dir,
    input  logic [7:0]               cmd_count,
    output logic                     done,
    output logic                     err,
    output logic                     busy,
    output logic [2:0]               ps_clksel,
    output logic                     ps_down,
    output logic                     ps_step,
    output logic                     pll_reset,
    output logic [NUM_OUT*POS_W-1:0] pos
);

    localparam int MAX_CYC = max_int(max_int(LOCK_WAIT, RST_CYC), max_int(PULSE_CYC, GAP_CYC));
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    state_t           state_q, state_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic [2:0]       ps_clksel_q, ps_clksel_d;
    logic             ps_down_q, ps_down_d;
    logic             ps_step_q, ps_step_d;
    logic             pll_reset_q, pll_reset_d;
    logic [7:0]       rem_q, rem_d;
    logic [POS_W-1:0] pos_q [NUM_OUT];
    logic [POS_W-1:0] pos_d [NUM_OUT];

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;
    logic             sel_bad;

    assign sel_bad = (int'(cmd_sel) >= NUM_OUT);

    // Position wraps modulo STEPS_PER_CYCLE in either direction.
    function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] p, input logic down);
        if (down) begin
            return (p == '0) ? POS_W'(STEPS_PER_CYCLE - 1) : p - POS_W'(1);
        end
        return (p == POS_W'(STEPS_PER_CYCLE - 1)) ? '0 : p + POS_W'(1);
    endfunction

    pll_ps_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmr_load),
        .load_val(tmr_val),
        .zero    (tmr_zero)
    );

    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        ps_clksel_d = ps_clksel_q;
        ps_down_d   = ps_down_q;
        ps_step_d   = ps_step_q;
        pll_reset_d = pll_reset_q;
        rem_d       = rem_q;
        pos_d       = pos_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    if (cmd_op == OP_HOME) begin
                        state_d     = ST_RST;
                        pll_reset_d = 1'b1;
                        tmr_load    = 1'b1;
                        tmr_val     = CNT_W'(RST_CYC - 1);
                        for (int k = 0; k < NUM_OUT; k++) pos_d[k] = '0;
                    end else if (sel_bad || cmd_count == 8'd0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = sel_bad;
                    end else begin
                        state_d     = ST_SETUP;
                        ps_clksel_d = cmd_sel;
                        ps_down_d   = cmd_dir;
                        rem_d       = cmd_count;
                    end
                end
            end
            ST_SETUP: begin
                state_d   = ST_PULSE;
                ps_step_d = 1'b1;
                tmr_load  = 1'b1;
                tmr_val   = CNT_W'(PULSE_CYC - 1);
                for (int k = 0; k < NUM_OUT; k++)
                    if (int'(ps_clksel_q) == k) pos_d[k] = step_pos(pos_q[k], ps_down_q);
            end
            ST_PULSE: begin
                if (tmr_zero) begin
                    state_d   = ST_GAP;
                    ps_step_d = 1'b0;
                    rem_d     = rem_q - 8'd1;
                    tmr_load  = 1'b1;
                    tmr_val   = CNT_W'(GAP_CYC - 1);
                end
            end
            ST_GAP: begin
                if (tmr_zero) begin
                    if (rem_q != 8'd0) begin
                        state_d   = ST_PULSE;
                        ps_step_d = 1'b1;
                        tmr_load  = 1'b1;
                        tmr_val   = CNT_W'(PULSE_CYC - 1);
                        for (int k = 0; k < NUM_OUT; k++)
                            if (int'(ps_clksel_q) == k) pos_d[k] = step_pos(pos_q[k], ps_down_q);
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_RST: begin
                if (tmr_zero) begin
                    state_d     = ST_WAIT;
                    pll_reset_d = 1'b0;
                    tmr_load    = 1'b1;
                    tmr_val     = CNT_W'(LOCK_WAIT - 1);
                end
            end
            ST_WAIT: begin
                if (tmr_zero) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            ps_clksel_q <= '0;
            ps_down_q   <= 1'b0;
            ps_step_q   <= 1'b0;
            pll_reset_q <= 1'b0;
            rem_q       <= '0;
            for (int k = 0; k < NUM_OUT; k++) pos_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            ps_clksel_q <= ps_clksel_d;
            ps_down_q   <= ps_down_d;
            ps_step_q   <= ps_step_d;
            pll_reset_q <= pll_reset_d;
            rem_q       <= rem_d;
            pos_q       <= pos_d;
        end
    end

    always_comb begin
        pos = '0;
        for (int k = 0; k < NUM_OUT; k++) pos[k*POS_W +: POS_W] = pos_q[k];
    end

    assign cmd_ready = cmd_ready_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign ps_clksel = ps_clksel_q;
    assign ps_down   = ps_down_q;
    assign ps_step   = ps_step_q;
    assign pll_reset = pll_reset_q;

endmodule

// File: tb/tb_pll_phase_stepper.sv
// Directed bench for pll_phase_stepper: stepping, wrap, invalid/zero commands, HOME and mid-pulse reset.
module tb_pll_phase_stepper;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [2:0]  cmd_sel;
    logic        cmd_dir;
    logic [7:0]  cmd_count;
    logic        done;
    logic        err;
    logic        busy;
    logic [2:0]  ps_clksel;
    logic        ps_down;
    logic        ps_step;
    logic        pll_reset;
    logic [11:0] pos;

    int tests = 0;
    int fails = 0;

    // statistics gathered by run_cmd
    int done_cyc, err_seen, step_hi, rises, rise1, rise2, rst_hi, rst_first, down_bad, busy_bad;

    pll_phase_stepper dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_sel  (cmd_sel),
        .cmd_dir  (cmd_dir),
        .cmd_count(cmd_count),
        .done     (done),
        .err      (err),
        .busy     (busy),
        .ps_clksel(ps_clksel),
        .ps_down  (ps_down),
        .ps_step  (ps_step),
        .pll_reset(pll_reset),
        .pos      (pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one command (accept edge = cycle 0) and watch until done or budget expires.
    task automatic run_cmd(input logic op, input logic [2:0] sel, input logic dir,
                           input logic [7:0] cnt, input int hold, input int budget);
        logic prev_step;
        @(negedge clk);
        cmd_op = op; cmd_sel = sel; cmd_dir = dir; cmd_count = cnt;
        cmd_valid = 1'b1;
        @(posedge clk);
        done_cyc = -1; err_seen = 0; step_hi = 0; rises = 0; rise1 = -1; rise2 = -1;
        rst_hi = 0; rst_first = -1; down_bad = 0; busy_bad = 0;
        prev_step = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (k > hold) cmd_valid = 1'b0;
            if (ps_step === 1'b1) begin
                step_hi++;
                if (!prev_step) begin
                    rises++;
                    if (rise1 < 0) rise1 = k;
                    else if (rise2 < 0) rise2 = k;
                end
            end
            prev_step = ps_step;
            if (pll_reset === 1'b1) begin
                rst_hi++;
                if (rst_first < 0) rst_first = k;
            end
            if (ps_down !== dir) down_bad++;
            if (busy !== 1'b1) busy_bad++;
            if (done === 1'b1) begin
                done_cyc = k;
                err_seen = int'(err);
                break;
            end
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        int extra;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_sel = '0; cmd_dir = 1'b0; cmd_count = '0;
        repeat (3) @(negedge clk);

        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_ps_step", ps_step, 0);
        check("rst_pll_reset", pll_reset, 0);
        check("rst_pos", pos, 0);
        check("rst_done", done, 0);

        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", cmd_ready, 1);

        // sel=1 down 2 from 0: 0 -> 39 -> 38
        run_cmd(1'b0, 3'd1, 1'b1, 8'd2, 0, 100);
        check("dn_done_cyc", done_cyc, 22);
        check("dn_err", err_seen, 0);
        check("dn_rises", rises, 2);
        check("dn_ps_down_stable", down_bad, 0);
        check("dn_busy", busy_bad, 0);
        check("dn_pos1", pos[11:6], 38);
        check("dn_pos0", pos[5:0], 0);
        check("dn_clksel", ps_clksel, 1);

        // sel=1 up 3 from 38: 39 -> 0 -> 1
        run_cmd(1'b0, 3'd1, 1'b0, 8'd3, 0, 100);
        check("up_done_cyc", done_cyc, 32);
        check("up_rises", rises, 3);
        check("up_step_width", step_hi, 6);
        check("up_first_rise", rise1, 2);
        check("up_second_rise", rise2, 12);
        check("up_busy", busy_bad, 0);
        check("up_pos1", pos[11:6], 1);
        check("up_pos0", pos[5:0], 0);
        @(negedge clk);
        check("idle_ready", cmd_ready, 1);
        check("idle_busy", busy, 0);
        check("idle_ps_down_kept", ps_down, 0);

        // invalid select
        run_cmd(1'b0, 3'd5, 1'b1, 8'd4, 0, 50);
        check("bad_done_cyc", done_cyc, 1);
        check("bad_err", err_seen, 1);
        check("bad_no_step", step_hi, 0);
        check("bad_pos", pos, 12'd1 << 6);
        check("bad_clksel_kept", ps_clksel, 1);

        // count 0 with cmd_valid still high during the busy cycle
        run_cmd(1'b0, 3'd0, 1'b0, 8'd0, 1, 50);
        check("zero_done_cyc", done_cyc, 1);
        check("zero_err", err_seen, 0);
        check("zero_no_step", step_hi, 0);
        extra = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1 || ps_step === 1'b1) extra++;
        end
        check("zero_no_reaccept", extra, 0);

        // sel=0 up 7 then HOME
        run_cmd(1'b0, 3'd0, 1'b0, 8'd7, 0, 200);
        check("seven_done_cyc", done_cyc, 72);
        check("seven_pos0", pos[5:0], 7);
        check("seven_pos1", pos[11:6], 1);

        run_cmd(1'b1, 3'd0, 1'b0, 8'd0, 0, 1200);
        check("home_done_cyc", done_cyc, 1041);
        check("home_rst_hi", rst_hi, 16);
        check("home_rst_first", rst_first, 1);
        check("home_no_step", step_hi, 0);
        check("home_busy", busy_bad, 0);
        check("home_pos", pos, 0);
        check("home_clksel_kept", ps_clksel, 0);

        // reset asserted while ps_step is high
        @(negedge clk);
        cmd_op = 1'b0; cmd_sel = 3'd0; cmd_dir = 1'b0; cmd_count = 8'd5; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("mid_step_high", ps_step, 1);
        check("mid_pos0", pos[5:0], 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_ps_step", ps_step, 0);
        check("async_pos", pos, 0);
        check("async_busy", busy, 0);
        check("async_ready", cmd_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", cmd_ready, 1);
        check("rel_ps_step", ps_step, 0);

        // recovery step after reset
        run_cmd(1'b0, 3'd0, 1'b0, 8'd1, 0, 50);
        check("rec_done_cyc", done_cyc, 12);
        check("rec_pos0", pos[5:0], 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
